mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Upstream front-end for one single-port, one-cycle-read-latency SRAM bank (the behavioural memory model or a hard macro).
- Accepts independent read and write request streams over valid/ready.
- Arbitrates them round-robin onto the bank's read/write/chip-enable controls so read and write are never issued in the same cycle.
- Returns read data with a response strobe, and gates chip enable off after a programmable idle period.

Parameters:
DEPTH, 528, words in the bank
DATA_W, 16, data word width in bits
ADDR_W, $clog2(DEPTH), address width
IDLE_TIMEOUT, 8, consecutive idle ACTIVE cycles before chip enable is dropped (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
rd_req_valid  input  1  read request present
rd_req_addr  input  ADDR_W  read address
rd_req_ready  output  1  read request accepted this cycle
wr_req_valid  input  1  write request present
wr_req_addr  input  ADDR_W  write address
wr_req_data  input  DATA_W  write data
wr_req_ready  output  1  write request accepted this cycle
rd_rsp_valid  output  1  rd_rsp_data holds data for the read accepted last cycle
rd_rsp_data  output  DATA_W  read data
mem_chip_en  output  1  bank chip enable
mem_wr_en  output  1  bank write strobe
mem_rd_en  output  1  bank read strobe
mem_wr_addr  output  ADDR_W  bank write address
mem_wr_data  output  DATA_W  bank write data
mem_rd_addr  output  ADDR_W  bank read address
mem_rd_data  input  DATA_W  bank registered read data

Behaviour:
- Interface (decided): single clock clk; rst is asynchronous, active-high. On rst: state=SLEEP, rr_last=WRITE (so read wins the first tie), idle_cnt=0, rd_rsp_valid=0. All outputs are 0 during reset.

FSM:
- SLEEP: mem_chip_en=0, both readys=0. Any valid -> WAKE.
- WAKE: exactly one cycle. mem_chip_en=1, readys=0. Always -> ACTIVE.
- ACTIVE: mem_chip_en=1. Arbitration enabled.
  - idle_cnt increments on cycles with neither valid and rd_rsp_valid=0.
  - idle_cnt clears on any valid.
  - When idle_cnt reaches IDLE_TIMEOUT-1 on an idle cycle -> SLEEP, clearing idle_cnt.

Arbitration (ACTIVE only, combinational grant):
- Only one valid: that port is granted.
- Both valid: grant the port not equal to rr_last. rr_last updates to the granted port.
- Grant drives ready=1 for the granted port only.
- Read grant: mem_rd_en=1, mem_rd_addr=rd_req_addr, mem_wr_en=0.
- Write grant: mem_wr_en=1, mem_wr_addr/mem_wr_data from the request, mem_rd_en=0.
- No grant: both strobes 0. Addresses and data are don't-care but must be held stable (last granted value) for power.

Invariants:
- mem_wr_en and mem_rd_en are never both 1.
- Neither strobe is ever 1 while mem_chip_en=0.

Response path:
- rd_rsp_valid is registered; it is 1 exactly the cycle after a read grant.
- rd_rsp_data = mem_rd_data passthrough, meaningful only while rd_rsp_valid=1.
- No backpressure on responses: the consumer must take the data that cycle.
- SLEEP entry is blocked while rd_rsp_valid=1, so chip enable stays high through data return.

Throughput and latency:
- 1 access per cycle in ACTIVE.
- Read latency: request accepted in cycle N -> rd_rsp_valid in N+1.
- From SLEEP, the first grant occurs 2 cycles after valid rises: SLEEP->WAKE edge, then WAKE->ACTIVE edge.

Other rules:
- Requesters hold valid/addr/data stable until ready.
- Reset mid-operation: a pending response is dropped (rd_rsp_valid=0) and the bank is disabled immediately.
- Address out of range (>=DEPTH): simulation assertion error; the access is still issued.
- Assertions: strobe exclusivity; no strobe without chip enable; valid must not drop before ready.

Decomposition:
- Package mem_pkg: mem_ctrl_state_t enum {SLEEP, WAKE, ACTIVE}; port_sel_t enum {SEL_READ, SEL_WRITE}; default DATA_W and DEPTH constants.
- Sub-module rr_arb2: 2-input round-robin arbiter (req[1:0], en, grant[1:0], rr_last register).
- FSM, idle counter and response register stay in mem_access_ctrl.

Test Plan:
- Cold start, wr_req_valid with addr=5, data=0xBEEF at cycle 0 -> WAKE at 1, wr_req_ready and mem_wr_en at cycle 2; no strobe while mem_chip_en=0.
- Write addr 5 = 0xBEEF, then read addr 5 -> rd_rsp_valid=1 with rd_rsp_data=0xBEEF exactly one cycle after rd_req_ready.
- Both valid continuously for 6 cycles -> grants alternate R,W,R,W,R,W; mem_rd_en&mem_wr_en=0 every cycle.
- Idle after last access with IDLE_TIMEOUT=8 -> mem_chip_en falls after 8 idle cycles. A single read before the idle run delays sleep until its response has returned.
- Valid arrives on the same edge SLEEP is entered -> WAKE next cycle, access granted 2 cycles later, no lost request.
- rst asserted the cycle after a read grant -> rd_rsp_valid=0 and mem_chip_en=0 immediately. After release, the state is SLEEP and the first tie is granted to read.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default sizes for the SRAM bank front-end
package mem_pkg;

  localparam int MEM_DEPTH  = 528;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {SLEEP, WAKE, ACTIVE} mem_ctrl_state_t;
  typedef enum logic {SEL_READ, SEL_WRITE} port_sel_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, bit 0 = read port, bit 1 = write port
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  port_sel_t rr_last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (rr_last == SEL_WRITE) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset to WRITE so the first tie after reset goes to the read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= SEL_WRITE;
    end else if (grant[0]) begin
      rr_last <= SEL_READ;
    end else if (grant[1]) begin
      rr_last <= SEL_WRITE;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - read/write request front-end for a single-port one-cycle SRAM bank
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH        = MEM_DEPTH,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_req_ready,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              wr_req_ready,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic              mem_chip_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int               CNT_W     = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  mem_ctrl_state_t   state, state_nxt;
  logic [CNT_W-1:0]  idle_cnt, idle_nxt;
  logic [1:0]        grant;
  logic              any_valid, rd_grant, wr_grant;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign any_valid = rd_req_valid | wr_req_valid;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({wr_req_valid, rd_req_valid}),
    .en   (state == ACTIVE),
    .grant(grant)
  );

  assign rd_grant     = grant[0];
  assign wr_grant     = grant[1];
  assign rd_req_ready = rd_grant;
  assign wr_req_ready = wr_grant;
  assign mem_rd_en    = rd_grant;
  assign mem_wr_en    = wr_grant;
  assign mem_chip_en  = (state != SLEEP);

  // Bank address/data lines keep the last granted value when idle to avoid toggling.
  assign mem_rd_addr = rd_grant ? rd_req_addr : rd_addr_q;
  assign mem_wr_addr = wr_grant ? wr_req_addr : wr_addr_q;
  assign mem_wr_data = wr_grant ? wr_req_data : wr_data_q;
  assign rd_rsp_data = rd_rsp_valid ? mem_rd_data : '0;

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    case (state)
      SLEEP: begin
        idle_nxt = '0;
        if (any_valid) state_nxt = WAKE;
      end
      WAKE: begin
        idle_nxt  = '0;
        state_nxt = ACTIVE;
      end
      ACTIVE: begin
        // A returning response holds the count so chip enable stays up for the data.
        if (any_valid) begin
          idle_nxt = '0;
        end else if (!rd_rsp_valid) begin
          if (idle_cnt == IDLE_LAST) begin
            state_nxt = SLEEP;
            idle_nxt  = '0;
          end else begin
            idle_nxt = idle_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = SLEEP;
        idle_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SLEEP;
      idle_cnt     <= '0;
      rd_rsp_valid <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state        <= state_nxt;
      idle_cnt     <= idle_nxt;
      rd_rsp_valid <= rd_grant;
      if (rd_grant) rd_addr_q <= rd_req_addr;
      if (wr_grant) begin
        wr_addr_q <= wr_req_addr;
        wr_data_q <= wr_req_data;
      end
    end
  end

`ifndef SYNTHESIS
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(DEPTH);

  a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_rd_en && mem_wr_en));
  a_strobe_ce:   assert property (@(posedge clk) disable iff (rst) (mem_rd_en || mem_wr_en) |-> mem_chip_en);
  a_rd_range:    assert property (@(posedge clk) disable iff (rst) mem_rd_en |-> ({1'b0, rd_req_addr} < ADDR_LIM));
  a_wr_range:    assert property (@(posedge clk) disable iff (rst) mem_wr_en |-> ({1'b0, wr_req_addr} < ADDR_LIM));
  a_rd_hold:     assert property (@(posedge clk) disable iff (rst) (rd_req_valid && !rd_req_ready) |=> rd_req_valid);
  a_wr_hold:     assert property (@(posedge clk) disable iff (rst) (wr_req_valid && !wr_req_ready) |=> wr_req_valid);
`endif

endmodule
